// File: rtl/uart_rx_os16.sv
// UART receiver driven by a 16x oversample strobe: recovers start/data/[parity]/stop frames
// from an async rx pin into a one-entry valid/ready buffer with registered error pulses.
module uart_rx_os16 #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned PARITY_ODD  = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxclk_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int unsigned      IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [3:0]       CNT_MID   = 4'd7;
    localparam logic [3:0]       CNT_END   = 4'd15;
    localparam logic             PARITY_ON = (PARITY_EN != 0);
    localparam logic             ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   parity_bad_c;
    logic                   push_ok_c;

    // rx metastability synchronizer; resets to the idle (high) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs          = sync_q[SYNC_STAGES-1];
    assign parity_bad_c = PARITY_ON && (par_q != ((^shreg) ^ ODD));
    assign push_ok_c    = !dout_valid || dout_ready;

    // Frame FSM plus output buffer; a push in the same cycle overrides the pop clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (rxclk_en) begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            cnt   <= 4'd0;
                            state <= START;
                        end
                    end
                    START: begin
                        if (cnt != CNT_MID) begin
                            cnt <= cnt + 4'd1;
                        end else if (rxs) begin
                            state <= IDLE;
                        end else begin
                            cnt     <= 4'd0;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        if (cnt != CNT_END) begin
                            cnt <= cnt + 4'd1;
                        end else begin
                            cnt            <= 4'd0;
                            shreg[bit_idx] <= rxs;
                            bit_idx        <= bit_idx + IDX_W'(1);
                            if (bit_idx == IDX_LAST) begin
                                state <= PARITY_ON ? PARITY : STOP;
                            end
                        end
                    end
                    PARITY: begin
                        if (cnt != CNT_END) begin
                            cnt <= cnt + 4'd1;
                        end else begin
                            cnt   <= 4'd0;
                            par_q <= rxs;
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (cnt != CNT_END) begin
                            cnt <= cnt + 4'd1;
                        end else begin
                            cnt <= 4'd0;
                            if (rxs) begin
                                // Return to IDLE at mid-stop so a following start edge is not missed
                                state <= IDLE;
                                if (parity_bad_c) begin
                                    parity_err <= 1'b1;
                                end else if (push_ok_c) begin
                                    dout       <= shreg;
                                    dout_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        if (rxs) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: an 8N1 instance and an even-parity instance,
// checked against a frame-level model of the one-entry receive buffer.
module tb_uart_rx_os16;

    logic       clk, tick, rst_n;
    logic       rx_a, rdy_a, rx_b, rdy_b;
    logic [7:0] dout_a, dout_b;
    logic       valid_a, fe_a, pe_a, ov_a;
    logic       valid_b, fe_b, pe_b, ov_b;
    int         phase;
    int         n_cmp, n_fail;
    int         fe_cnt_a, ov_cnt_a, pe_cnt_a, pe_cnt_b, fe_cnt_b;

    // frame-level model of instance A's buffer and error counts
    logic [7:0] m_dout;
    logic       m_valid;
    int         m_fe, m_ov;
    logic [7:0] mb_dout;
    logic       mb_valid;
    int         mb_pe;

    uart_rx_os16 #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .rxclk_en(tick), .rx(rx_a),
        .dout(dout_a), .dout_valid(valid_a), .dout_ready(rdy_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

    uart_rx_os16 #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .rxclk_en(tick), .rx(rx_b),
        .dout(dout_b), .dout_valid(valid_b), .dout_ready(rdy_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

    // clock with a 16x tick every 4th cycle, updated on the falling edge
    initial begin
        clk = 0; tick = 0; phase = 0;
        forever begin
            #5 clk = 1;
            #5 clk = 0;
            tick  = (phase == 3);
            phase = (phase + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (fe_a) fe_cnt_a++;
        if (ov_a) ov_cnt_a++;
        if (pe_a) pe_cnt_a++;
        if (pe_b) pe_cnt_b++;
        if (fe_b) fe_cnt_b++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Serial send, 64 clk per bit; optionally pulses rdy_a for one cycle at clk index pulse_at
    // and reports the clk index at which an overrun pulse on A was first seen.
    task automatic send(input bit to_b, input logic [15:0] bits, input int n,
                        input int pulse_at, output int ov_at);
        int k;
        k = 0;
        ov_at = -1;
        while (phase != 0) step();
        for (int b = 0; b < n; b++) begin
            if (to_b) rx_b = bits[b]; else rx_a = bits[b];
            for (int c = 0; c < 64; c++) begin
                if (k == pulse_at) rdy_a = 1'b1;
                else if (k == pulse_at + 1) rdy_a = 1'b0;
                step();
                k++;
                if (ov_a && ov_at < 0) ov_at = k;
            end
        end
        rdy_a = 1'b0;
        rx_a = 1'b1;
        rx_b = 1'b1;
    endtask

    task automatic send_a(input logic [7:0] d, input bit stop, input bit rdy_at_done,
                          input int pulse_at, output int ov_at);
        send(1'b0, {6'b0, stop, d, 1'b0}, 10, pulse_at, ov_at);
        if (!stop) m_fe++;
        else if (!m_valid || rdy_at_done) begin m_dout = d; m_valid = 1'b1; end
        else m_ov++;
    endtask

    task automatic send_b(input logic [7:0] d, input bit par);
        int unused;
        send(1'b1, {5'b0, 1'b1, par, d, 1'b0}, 11, -10, unused);
        if (par != (^d)) mb_pe++;
        else if (!mb_valid) begin mb_dout = d; mb_valid = 1'b1; end
    endtask

    task automatic check_a(input string tag);
        n_cmp++; if (dout_a !== m_dout) begin n_fail++; $display("FAIL %s dout_a got %h exp %h", tag, dout_a, m_dout); end
        n_cmp++; if (valid_a !== m_valid) begin n_fail++; $display("FAIL %s valid_a got %b exp %b", tag, valid_a, m_valid); end
        n_cmp++; if (fe_cnt_a !== m_fe) begin n_fail++; $display("FAIL %s frame_err count got %0d exp %0d", tag, fe_cnt_a, m_fe); end
        n_cmp++; if (ov_cnt_a !== m_ov) begin n_fail++; $display("FAIL %s overrun count got %0d exp %0d", tag, ov_cnt_a, m_ov); end
        n_cmp++; if (pe_cnt_a !== 0) begin n_fail++; $display("FAIL %s parity_err count on A got %0d exp 0", tag, pe_cnt_a); end
    endtask

    task automatic pop_a(input string tag);
        rdy_a = 1'b1;
        step();
        rdy_a = 1'b0;
        m_valid = 1'b0;
        n_cmp++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL %s pop valid_a got %b exp 0", tag, valid_a); end
        n_cmp++; if (dout_a !== m_dout) begin n_fail++; $display("FAIL %s pop dout_a got %h exp %h", tag, dout_a, m_dout); end
    endtask

    task automatic test_reset();
        n_cmp++; if ({dout_a, valid_a, fe_a, pe_a, ov_a} !== 12'h0) begin n_fail++; $display("FAIL reset A outputs got %h exp 000", {dout_a, valid_a, fe_a, pe_a, ov_a}); end
        n_cmp++; if ({dout_b, valid_b, fe_b, pe_b, ov_b} !== 12'h0) begin n_fail++; $display("FAIL reset B outputs got %h exp 000", {dout_b, valid_b, fe_b, pe_b, ov_b}); end
    endtask

    task automatic test_random_bytes();
        int u;
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            d = (i == 0) ? 8'hA5 : 8'($urandom);
            send_a(d, 1'b1, 1'b0, -10, u);
            check_a("rand_frame");
            idle(100);
            check_a("rand_hold");
            pop_a("rand");
        end
    endtask

    task automatic test_glitch();
        int u;
        rx_a = 1'b0;
        idle(16);
        rx_a = 1'b1;
        idle(300);
        check_a("glitch");
        send_a(8'($urandom), 1'b1, 1'b0, -10, u);
        check_a("after_glitch");
        pop_a("after_glitch");
    endtask

    task automatic test_break();
        int u;
        send_a(8'h3C, 1'b0, 1'b0, -10, u);
        rx_a = 1'b0;
        idle(800);
        check_a("break_low");
        rx_a = 1'b1;
        idle(64);
        check_a("break_release");
        send_a(8'h11, 1'b1, 1'b0, -10, u);
        check_a("after_break");
        pop_a("after_break");
    endtask

    task automatic test_back_to_back();
        int u, ov1, ov2;
        send_a(8'h01, 1'b1, 1'b0, -10, u);
        send_a(8'h02, 1'b1, 1'b0, -10, ov1);
        check_a("b2b_overrun");
        n_cmp++; if (ov1 <= 1) begin n_fail++; $display("FAIL b2b overrun position got %0d exp >1", ov1); end
        pop_a("b2b_overrun");
        idle(100);
        send_a(8'h01, 1'b1, 1'b0, -10, u);
        send_a(8'h02, 1'b1, 1'b1, ov1 - 1, ov2);
        check_a("b2b_pop_push");
        pop_a("b2b_pop_push");
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic       p;
        send_b(8'h07, 1'b0);
        send_b(8'h07, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                d = 8'h07; p = 1'b0;
            end else begin
                rdy_b = 1'b1; step(); rdy_b = 1'b0; mb_valid = 1'b0;
                d = 8'($urandom); p = 1'($urandom);
                send_b(d, p);
            end
            n_cmp++; if (pe_cnt_b !== mb_pe) begin n_fail++; $display("FAIL parity count got %0d exp %0d", pe_cnt_b, mb_pe); end
            n_cmp++; if (valid_b !== mb_valid) begin n_fail++; $display("FAIL parity valid_b got %b exp %b", valid_b, mb_valid); end
            n_cmp++; if (dout_b !== mb_dout) begin n_fail++; $display("FAIL parity dout_b got %h exp %h", dout_b, mb_dout); end
            n_cmp++; if (fe_cnt_b !== 0) begin n_fail++; $display("FAIL parity frame_err count got %0d exp 0", fe_cnt_b); end
        end
    endtask

    task automatic test_reset_midframe();
        int u;
        logic [7:0] d;
        d = 8'($urandom) | 8'h01;
        send_a(d, 1'b1, 1'b0, -10, u);
        check_a("pre_reset");
        send(1'b0, {8'hFF, 8'hC6, 1'b0} >> 0, 4, -10, u);
        rx_a = 1'b1;
        idle(32);
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0; m_dout = 8'h00;
        n_cmp++; if ({dout_a, valid_a, fe_a, pe_a, ov_a} !== 12'h0) begin n_fail++; $display("FAIL midframe reset outputs got %h exp 000", {dout_a, valid_a, fe_a, pe_a, ov_a}); end
        idle(5);
        rst_n = 1'b1;
        idle(200);
        check_a("post_reset_idle");
        send_a(8'h5A, 1'b1, 1'b0, -10, u);
        check_a("post_reset_frame");
        pop_a("post_reset_frame");
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        fe_cnt_a = 0; ov_cnt_a = 0; pe_cnt_a = 0; pe_cnt_b = 0; fe_cnt_b = 0;
        m_dout = 8'h00; m_valid = 1'b0; m_fe = 0; m_ov = 0;
        mb_dout = 8'h00; mb_valid = 1'b0; mb_pe = 0;
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
        idle(5);
        test_reset();
        rst_n = 1'b1;
        idle(50);
        test_random_bytes();
        test_glitch();
        test_break();
        test_back_to_back();
        test_parity();
        test_reset_midframe();
        idle(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
